serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder that consumes operand pairs and produces `{carry,sum}` one bit per clock, LSB first. It reuses the team's combinational `half_adder` cell: two of them form a full adder, and a carry flip-flop closes the loop. It sits directly downstream of the half adder in the adder family and is the first sequential arithmetic stage. It trades latency for area against a parallel ripple adder.

## Interface
- `WIDTH`, default 8: operand width in bits. Legal range is WIDTH ≥ 2.
- `i_clk` (input, 1): the single clock; all state is updated on the rising edge.
- `i_rst_n` (input, 1): asynchronous, active-low reset.
- `i_start` (input, 1): request to add `i_a` and `i_b`. It is sampled only in IDLE.
- `i_a` (input, WIDTH): operand A, captured on the edge that accepts `i_start`.
- `i_b` (input, WIDTH): operand B, captured on the same edge.
- `o_busy` (output, 1): high while in ADD.
- `o_done` (output, 1): one-cycle pulse indicating the result is valid.
- `o_sum` (output, WIDTH): result sum, registered.
- `o_carry` (output, 1): result carry-out, registered.

## Operation
- FSM states are IDLE, ADD and DONE.
- **IDLE**
  - If `i_start`=1: load `a_sr`←`i_a`, `b_sr`←`i_b`, `c_reg`←0, `cnt`←0, then go to ADD.
  - Otherwise stay in IDLE.
- **ADD**, once per cycle:
  - Compute `{cout,s}` = `a_sr[0]` + `b_sr[0]` + `c_reg` through the full adder.
  - `sum_sr`←`{s, sum_sr[WIDTH-1:1]}`.
  - Shift `a_sr` and `b_sr` right by one (zero fill).
  - `c_reg`←`cout`, `cnt`←`cnt`+1.
  - When `cnt`==WIDTH-1: on that same edge, load `o_sum`←`{s, sum_sr[WIDTH-1:1]}` and `o_carry`←`cout`, then go to DONE.
- **DONE**:
  - `o_done`=1 for exactly one cycle, then go to IDLE unconditionally.
  - `i_start` is ignored in DONE.
- **Start while busy:** `i_start` in ADD or DONE is ignored. It is neither queued nor allowed to corrupt the operation in flight.
- **Output hold:** `o_sum` and `o_carry` hold the last result until the next completion. They never show partial values.
- **Width rules:**
  - `cnt` is `$clog2(WIDTH)` bits wide.
  - The result is mathematically `{o_carry,o_sum}` = `i_a` + `i_b`, a (WIDTH+1)-bit unsigned sum.
  - There is no overflow flag beyond `o_carry`.
- **Reset:**
  - `i_rst_n`=0 at any time forces IDLE immediately.
  - All outputs are cleared: `o_busy`=0, `o_done`=0, `o_sum`=0, `o_carry`=0.
  - Internal registers are cleared: `a_sr`, `b_sr`, `sum_sr`, `c_reg` and `cnt` all go to 0.
  - An operation interrupted by reset produces no `o_done` and leaves no stale result.

## Timing
- `i_start` is accepted on rising edge k, and ADD occupies edges k+1 … k+WIDTH.
- `o_busy` is high after edge k until edge k+WIDTH.
- `o_done` is high from edge k+WIDTH to edge k+WIDTH+1.
- The new `o_sum` and `o_carry` appear at edge k+WIDTH, coincident with `o_done` rising.
- The earliest next accept is edge k+WIDTH+2, giving a throughput of one add per WIDTH+2 cycles.
- All outputs are driven directly from flops. The only combinational path is the full-adder feedback path inside ADD.
- Reset deassertion is synchronised externally. The block requires that `i_start` is low during the first cycle after release.

## Structure
- **Package `serial_adder_pkg`:**
  - The state encoding localparams: IDLE=2'd0, ADD=2'd1, DONE=2'd2.
  - The default WIDTH constant.
- **Sub-module `full_adder`:**
  - Ports `i_a`, `i_b`, `i_cin`, `sum`, `carry`.
  - Built from two `half_adder` instances, with `carry` = `carry1` | `carry2`.
  - It is instantiated once in `serial_adder` and gets its own exhaustive 8-vector bench.
- **Top level:** the FSM, `cnt`, the three shift registers, `c_reg` and the output registers, all in `serial_adder`. No other hierarchy.

## Test plan
All scenarios use WIDTH=8.
- **Carry ripple:** `i_a`=8'hFF, `i_b`=8'h01, start → `o_done` exactly 8 edges after accept, with `o_sum`=8'h00 and `o_carry`=1.
- **No-carry full word:** `i_a`=8'hA5, `i_b`=8'h5A → `o_sum`=8'hFF, `o_carry`=0. Also `i_a`=8'h80, `i_b`=8'h80 → `o_sum`=8'h00, `o_carry`=1.
- **Start while busy:** accept 8'h03+8'h04, then pulse `i_start` with 8'hFF/8'hFF during ADD and during DONE → single `o_done`, `o_sum`=8'h07, `o_carry`=0. The following IDLE start is then accepted normally.
- **Reset mid-operation:** assert `i_rst_n`=0 at cnt=3 of an 8'hF0+8'h0F add → outputs are 0 immediately and no `o_done` appears. A subsequent 8'h01+8'h01 add yields 8'h02.
- **Output hold:** after a result, idle for 20 cycles with `i_a`/`i_b` toggling → `o_sum`/`o_carry` are unchanged and `o_done` stays low.
- **Random regression:** 200 random operand pairs back-to-back at maximum rate. Each result is compared against the reference `{carry,sum}`=`a`+`b`. The bench prints "Test case Passed/Failed" per case and a final error count of 0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder.
// State encoding and default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// Full adder built from two half adder cells.
// Carry-out is the OR of both partial carries.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic sum,
  output logic carry
);

  logic w_s1;
  logic w_carry1;
  logic w_carry2;

  half_adder u_ha0 (
    .i_a   (i_a),
    .i_b   (i_b),
    .sum   (w_s1),
    .carry (w_carry1)
  );

  half_adder u_ha1 (
    .i_a   (w_s1),
    .i_b   (i_cin),
    .sum   (sum),
    .carry (w_carry2)
  );

  assign carry = w_carry1 | w_carry2;

endmodule

// File: rtl/half_adder.sv
// Combinational half adder cell.
// Base building block of the adder family.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic sum,
  output logic carry
);

  assign sum   = i_a ^ i_b;
  assign carry = i_a & i_b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Result {carry,sum} is registered and held until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_c_reg;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_sum_next;

  full_adder u_fa (
    .i_a   (r_a_sr[0]),
    .i_b   (r_b_sr[0]),
    .i_cin (r_c_reg),
    .sum   (w_s),
    .carry (w_cout)
  );

  assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_c_reg  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a_sr  <= i_a;
            r_b_sr  <= i_b;
            r_c_reg <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_sum_sr <= w_sum_next;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_c_reg  <= w_cout;
          r_cnt    <= r_cnt + 1'b1;
          // Final bit: publish result together with done.
          if (r_cnt == LAST) begin
            r_sum   <= w_sum_next;
            r_carry <= w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_sum   = r_sum;
  assign o_carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed cases plus random
// back-to-back regression against an arithmetic reference.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W:0]   res;
    int           cyc;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  logic fa_a, fa_b, fa_c, fa_s, fa_co;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [W:0] last_res = '0;
  logic prev_done = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_carry (carry)
  );

  full_adder u_fa (
    .i_a   (fa_a),
    .i_b   (fa_b),
    .i_cin (fa_c),
    .sum   (fa_s),
    .carry (fa_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected results whenever the DUT signals done.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width: done high two cycles, want 1");
      end
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_done: got done, want none at cyc %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({carry, sum} !== e.res || cyc != e.cyc || busy !== 1'b0) begin
          errors++;
          $display("FAIL result %h+%h: got %h cyc %0d busy %b, want %h cyc %0d busy 0",
                   e.a, e.b, {carry, sum}, cyc, busy, e.res, e.cyc);
          if (e.cyc > 0) $display("Test case Failed");
        end else begin
          $display("Test case Passed");
        end
      end
    end
    prev_done = done;
  end

  // Caller is just past a posedge; returns 1ns after the accept edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    #1;
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.res = {1'b0, x} + {1'b0, y};
    e.cyc = cyc + W;
    e.a = x;
    e.b = y;
    last_res = e.res;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    repeat (W + 1) @(posedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    fa_a = 0; fa_b = 0; fa_c = 0;

    // Full adder cell, exhaustive.
    for (int v = 0; v < 8; v++) begin
      fa_a = v[0]; fa_b = v[1]; fa_c = v[2];
      #1;
      chk("full_adder", {30'd0, fa_co, fa_s},
          32'(v[0]) + 32'(v[1]) + 32'(v[2]));
    end

    #2;
    chk("reset_out", {22'd0, busy, done, carry, sum}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);

    // Directed results.
    issue(8'hFF, 8'h01); wait_idle();
    issue(8'hA5, 8'h5A); wait_idle();
    issue(8'h80, 8'h80); wait_idle();

    // Start while busy (ADD and DONE) is ignored.
    issue(8'h03, 8'h04);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (W - 3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("no_requeue", {31'd0, busy}, 32'd0);
    @(posedge clk);
    issue(8'h11, 8'h22); wait_idle();

    // Reset in the middle of an add.
    issue(8'hF0, 8'h0F);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_reset_out", {22'd0, busy, done, carry, sum}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (W + 4) @(posedge clk);
    chk("no_done_after_reset", {22'd0, busy, done, carry, sum}, 32'd0);
    issue(8'h01, 8'h01); wait_idle();

    // Output hold while idle with toggling operands.
    for (int i = 0; i < 20; i++) begin
      #1 a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk("hold", {22'd0, busy, done, carry, sum}, {22'd0, 2'b00, last_res});
      @(posedge clk);
    end

    // Random back-to-back regression at maximum rate.
    for (int i = 0; i < 200; i++) begin
      issue(8'($urandom), 8'($urandom));
      wait_idle();
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
